spi_slave_sync: RTL and testbench
=================================

// Module: spi_slave_sync
// PURPOSE
//  Parametrised SPI slave, fully synchronous to sys_clk. Oversamples ss/sclk/mosi, supports all four SPI modes.
//  Streams back-to-back words while ss held. Registered TX holding buffer with ready/load handshake;
//  RX word register with valid/ack handshake. Sticky overrun/underrun flags.
//  Sits between the external SPI pins and the register/command logic on sys_clk.
// PARAMETERS
//  DATA_W     8  bits per SPI word (2..32)
//  CPOL       0  sclk idle level
//  CPHA       0  0: sample on leading edge, first bit driven at select; 1: shift on leading edge, sample on trailing
//  MSB_FIRST  1  1: MSB shifted first; 0: LSB first
//  SYNC_STG   2  synchroniser flops on ss/sclk/mosi (>=2)
// PORTS
//  sys_clk     in   1       system clock; all logic on rising edge
//  rst         in   1       synchronous, active-high reset
//  ss          in   1       slave select, active-high, async to sys_clk
//  sclk        in   1       SPI clock, async
//  mosi        in   1       SPI data in, async
//  miso        out  1       SPI data out (registered)
//  tx_data     in   DATA_W  word to transmit
//  tx_load     in   1       write tx_data into holding reg (honoured only when tx_ready)
//  tx_ready    out  1       holding reg empty
//  rx_data     out  DATA_W  last complete received word
//  rx_valid    out  1       rx_data holds an unacknowledged word
//  rx_ack      in   1       consume rx_data
//  clr_flags   in   1       clear overrun/underrun
//  overrun     out  1       sticky: word completed while rx_valid=1 and no rx_ack
//  underrun    out  1       sticky: word started with empty holding reg
//  busy        out  1       frame in progress (synced ss high)
// BEHAVIOUR
//  Reset: miso=0, rx_data=0, rx_valid=0, tx_ready=1, overrun=0, underrun=0, busy=0, bit_cnt=0, FSM=IDLE.
//  Inputs pass SYNC_STG flops; edges detected on synced sclk. Lead edge = transition away from CPOL level.
//  Sample edge = lead if CPHA=0 else trail; shift edge = the other. Edge-to-action latency SYNC_STG+1 cycles.
//  Required: sclk high and low phases each >= SYNC_STG+2 sys_clk.
//  FSM IDLE -> ACTIVE on synced ss rise: load shifter from holding (tx_ready->1 next cycle); if empty,
//    load 0s and set underrun. bit_cnt=0. CPHA=0: miso drives first bit same cycle; CPHA=1: on first shift edge.
//  ACTIVE, sample edge: shift mosi into rx shifter, bit_cnt+1. At bit_cnt==DATA_W: wrap to 0, publish word,
//    reload TX shifter from holding (underrun rules as above); stay ACTIVE for next word.
//  ACTIVE, shift edge: drive next TX bit on miso (skipped on the shift edge that follows a reload when CPHA=0).
//  Publish: if !rx_valid or rx_ack same cycle -> rx_data<=word, rx_valid=1. Else word dropped, overrun=1,
//    rx_data unchanged.
//  rx_ack with rx_valid=0: no effect. tx_load with tx_ready=0: ignored, holding unchanged.
//  tx_load coincident with holding consumption: consumption sees old state; load accepted only if tx_ready was 1.
//  ACTIVE -> IDLE on synced ss fall, any bit_cnt: partial word discarded (no rx_valid), bit_cnt=0, miso=0.
//  Holding reg content is retained across frames.
//  clr_flags clears both flags; a flag set in the same cycle wins (stays 1).
//  sclk edges while IDLE are ignored. rst mid-frame: immediate return to reset state, frame lost.
// STRUCTURE
//  Package spi_pkg: FSM state enum (IDLE, ACTIVE), CPOL/CPHA mode constants, DATA_W range checks.
//  Sub-module spi_sync_edge: SYNC_STG-flop synchroniser + rise/fall pulse outputs; one instance each for ss
//    and sclk, plain synchroniser for mosi. Shifters, bit counter, holding reg and FSM live in top level.
//  Bit ordering handled by MSB_FIRST generate on shift direction only.
// TESTING
//  Mode 0, DATA_W=8: tx_load 0xA5, master sends 0x3C in one frame -> rx_data=0x3C, rx_valid=1, miso bits=0xA5.
//  Modes 1/2/3 each: same exchange -> identical rx_data/miso words; MSB_FIRST=0 run -> bit-reversed wire order.
//  Two words in one frame, rx_ack withheld: 0x11, 0x22 -> rx_data=0x11, overrun=1; clr_flags -> overrun=0.
//  No tx_load before frame -> miso all 0, underrun=1; tx_load while tx_ready=0 -> ignored, holding unchanged.
//  ss drops after 5 bits -> rx_valid stays 0, busy=0, next full frame 0x81 received correctly.
//  rst asserted mid-word -> all outputs at reset values next cycle; DATA_W=16 frame 0xBEEF passes after.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the sys_clk-synchronous SPI slave.
package spi_pkg;

  // Frame state: waiting for select, or shifting words while select is held.
  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_t;

  // Clock polarity: level of sclk between frames.
  localparam bit CPOL_IDLE_LOW  = 1'b0;
  localparam bit CPOL_IDLE_HIGH = 1'b1;

  // Clock phase: which sclk edge captures mosi.
  localparam bit CPHA_LEAD_SAMPLE  = 1'b0;
  localparam bit CPHA_TRAIL_SAMPLE = 1'b1;

  // Legal parameter ranges.
  localparam int DATA_W_MIN   = 2;
  localparam int DATA_W_MAX   = 32;
  localparam int SYNC_STG_MIN = 2;

  function automatic bit data_w_ok(input int w);
    return (w >= DATA_W_MIN) && (w <= DATA_W_MAX);
  endfunction

  function automatic bit sync_stg_ok(input int n);
    return n >= SYNC_STG_MIN;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, with single-cycle
// rise/fall pulses derived from the synchronised level.
module spi_sync_edge #(
  parameter int SYNC_STG = 2,
  parameter bit RST_VAL  = 1'b0
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STG-1:0] sync_q;
  logic                level_d;
  logic                level;

  // Synchroniser chain plus one delayed copy of the synchronised level.
  // The reset value matches the pin's idle level so that leaving reset
  // never produces a spurious edge.
  always_ff @(posedge sys_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would
    // collapse the chain into a single flop.
    if (rst) begin
      sync_q  <= {SYNC_STG{RST_VAL}};
      level_d <= RST_VAL;
    end else begin
      sync_q  <= {sync_q[SYNC_STG-2:0], din};
      level_d <= level;
    end
  end

  assign level = sync_q[SYNC_STG-1];
  assign rise  = level & ~level_d;
  assign fall  = ~level & level_d;

endmodule

// File: rtl/spi_slave_sync.sv
// SPI slave fully synchronous to sys_clk. The pins are oversampled, all four
// SPI modes are supported, words stream back-to-back while ss stays high,
// TX uses a one-word holding register (ready/load), RX publishes into a word
// register (valid/ack), and overrun/underrun are sticky until cleared.
module spi_slave_sync
  import spi_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter bit MSB_FIRST = 1'b1,
  parameter int SYNC_STG  = 2
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              ss,
  input  logic              sclk,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
  input  logic              clr_flags,
  output logic              overrun,
  output logic              underrun,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);

  // Elaboration-time guard on the parameter ranges.
  if (!data_w_ok(DATA_W) || !sync_stg_ok(SYNC_STG)) begin : g_param_check
    $error("spi_slave_sync: DATA_W must be 2..32 and SYNC_STG >= 2");
  end

  // ------------------------------------------------------------------
  // Pin synchronisation and edge decode
  // ------------------------------------------------------------------
  logic ss_rise, ss_fall;
  logic sclk_rise, sclk_fall;
  logic [SYNC_STG-1:0] mosi_sync_q;
  logic mosi_s;

  spi_sync_edge #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b0)) u_ss_sync (
    .sys_clk (sys_clk),
    .rst     (rst),
    .din     (ss),
    .rise    (ss_rise),
    .fall    (ss_fall)
  );

  spi_sync_edge #(.SYNC_STG(SYNC_STG), .RST_VAL(CPOL)) u_sclk_sync (
    .sys_clk (sys_clk),
    .rst     (rst),
    .din     (sclk),
    .rise    (sclk_rise),
    .fall    (sclk_fall)
  );

  // mosi runs through the same depth as sclk, so the synchronised data bit
  // lines up with the synchronised sclk edge that captures it.
  always_ff @(posedge sys_clk) begin
    if (rst) mosi_sync_q <= '0;
    else     mosi_sync_q <= {mosi_sync_q[SYNC_STG-2:0], mosi};
  end

  assign mosi_s = mosi_sync_q[SYNC_STG-1];

  logic lead_edge, trail_edge, sample_edge, shift_edge;

  assign lead_edge   = (CPOL == CPOL_IDLE_LOW) ? sclk_rise : sclk_fall;
  assign trail_edge  = (CPOL == CPOL_IDLE_LOW) ? sclk_fall : sclk_rise;
  assign sample_edge = (CPHA == CPHA_LEAD_SAMPLE) ? lead_edge  : trail_edge;
  assign shift_edge  = (CPHA == CPHA_LEAD_SAMPLE) ? trail_edge : lead_edge;

  // ------------------------------------------------------------------
  // Frame FSM
  // ------------------------------------------------------------------
  spi_state_t state, state_nxt;
  logic start, stop, sample_en, shift_en;

  // State register.
  always_ff @(posedge sys_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: select rise opens a frame, select fall closes it at any bit.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first; a path that leaves one unassigned would infer a latch.
    state_nxt = state;
    unique case (state)
      IDLE:    if (ss_rise) state_nxt = ACTIVE;
      ACTIVE:  if (ss_fall) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: frame start/stop strobes and sclk actions gated by
  // state, so sclk edges seen while IDLE do nothing.
  always_comb begin
    start     = 1'b0;
    stop      = 1'b0;
    sample_en = 1'b0;
    shift_en  = 1'b0;
    unique case (state)
      IDLE:   start = ss_rise;
      ACTIVE: begin
        stop      = ss_fall;
        sample_en = sample_edge & ~ss_fall;
        shift_en  = shift_edge & ~ss_fall;
      end
      default: ;
    endcase
  end

  assign busy = (state == ACTIVE);

  // ------------------------------------------------------------------
  // Bit counter and word boundary
  // ------------------------------------------------------------------
  logic [CNT_W-1:0] bit_cnt;
  logic             word_done;
  logic             consume;

  assign word_done = sample_en && (bit_cnt == CNT_W'(DATA_W - 1));
  // The holding register is drained at frame start and at every word end.
  assign consume   = start | word_done;

  // Count sampled bits; wrap at the word boundary, clear on frame edges.
  always_ff @(posedge sys_clk) begin
    if (rst)                bit_cnt <= '0;
    else if (start || stop) bit_cnt <= '0;
    else if (word_done)     bit_cnt <= '0;
    else if (sample_en)     bit_cnt <= bit_cnt + CNT_W'(1);
  end

  // ------------------------------------------------------------------
  // Shift direction (the only place bit order matters)
  // ------------------------------------------------------------------
  logic [DATA_W-1:0] tx_hold;
  logic [DATA_W-1:0] tx_word;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] tx_word_sh;
  logic [DATA_W-1:0] tx_shift_sh;
  logic              tx_word_head;
  logic              tx_shift_head;
  logic [DATA_W-2:0] rx_shift;
  logic [DATA_W-1:0] rx_word;
  logic [DATA_W-2:0] rx_shift_nxt;

  // An empty holding register transmits zeros.
  assign tx_word = tx_ready ? '0 : tx_hold;

  if (MSB_FIRST) begin : g_msb_first
    assign tx_word_head  = tx_word[DATA_W-1];
    assign tx_word_sh    = {tx_word[DATA_W-2:0], 1'b0};
    assign tx_shift_head = tx_shift[DATA_W-1];
    assign tx_shift_sh   = {tx_shift[DATA_W-2:0], 1'b0};
    assign rx_word       = {rx_shift, mosi_s};
    assign rx_shift_nxt  = rx_word[DATA_W-2:0];
  end else begin : g_lsb_first
    assign tx_word_head  = tx_word[0];
    assign tx_word_sh    = {1'b0, tx_word[DATA_W-1:1]};
    assign tx_shift_head = tx_shift[0];
    assign tx_shift_sh   = {1'b0, tx_shift[DATA_W-1:1]};
    assign rx_word       = {mosi_s, rx_shift};
    assign rx_shift_nxt  = rx_word[DATA_W-1:1];
  end

  // ------------------------------------------------------------------
  // TX holding register
  // ------------------------------------------------------------------
  // A load is honoured only while empty; consumption looks at the pre-edge
  // state, so a load in the same cycle as an empty consumption still lands.
  always_ff @(posedge sys_clk) begin
    // NOTE: the holding register is reset even though tx_ready marks it
    // empty; a defined value keeps simulation free of X on tx_word.
    if (rst) begin
      tx_hold  <= '0;
      tx_ready <= 1'b1;
    end else if (tx_load && tx_ready) begin
      tx_hold  <= tx_data;
      tx_ready <= 1'b0;
    end else if (consume) begin
      tx_ready <= 1'b1;
    end
  end

  // ------------------------------------------------------------------
  // TX shifter and miso
  // ------------------------------------------------------------------
  // With CPHA=0 the first bit must be on miso before the first sample edge,
  // so a (re)load presents the head bit immediately and keeps the rest; the
  // trailing edge right after a mid-frame reload would otherwise skip a bit,
  // hence skip_shift. With CPHA=1 the shifter holds undriven bits and each
  // leading edge drives the next one.
  logic skip_shift;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      tx_shift   <= '0;
      miso       <= 1'b0;
      skip_shift <= 1'b0;
    end else if (stop) begin
      miso       <= 1'b0;
      skip_shift <= 1'b0;
    end else if (consume) begin
      if (CPHA == CPHA_LEAD_SAMPLE) begin
        miso       <= tx_word_head;
        tx_shift   <= tx_word_sh;
        skip_shift <= word_done;
      end else begin
        tx_shift   <= tx_word;
      end
    end else if (shift_en) begin
      if (skip_shift) begin
        skip_shift <= 1'b0;
      end else begin
        miso     <= tx_shift_head;
        tx_shift <= tx_shift_sh;
      end
    end
  end

  // ------------------------------------------------------------------
  // RX shifter, word register and flags
  // ------------------------------------------------------------------
  logic publish_ok;
  logic overrun_set;
  logic underrun_set;

  assign publish_ok   = !rx_valid || rx_ack;
  assign overrun_set  = word_done && !publish_ok;
  assign underrun_set = consume && tx_ready;

  // Capture sampled mosi bits; a partial word is simply abandoned.
  always_ff @(posedge sys_clk) begin
    if (rst)            rx_shift <= '0;
    else if (sample_en) rx_shift <= rx_shift_nxt;
  end

  // Publish a completed word if the register is free (or freed this cycle).
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else if (word_done && publish_ok) begin
      rx_data  <= rx_word;
      rx_valid <= 1'b1;
    end else if (rx_ack) begin
      rx_valid <= 1'b0;
    end
  end

  // Sticky flags; a set in the same cycle as a clear wins.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      overrun  <= overrun_set  | (overrun  & ~clr_flags);
      underrun <= underrun_set | (underrun & ~clr_flags);
    end
  end

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench for spi_slave_sync: six instances cover modes 0-3, LSB-first
// and a 16-bit word. A bench-side SPI master drives the pins; expected words
// go into a scoreboard queue as each exchange is launched.
module tb_spi_slave_sync;

  localparam int N_DUT = 6;
  localparam int HALF  = 8;   // sys_clk cycles per sclk phase

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic        ss_a        [N_DUT];
  logic        sclk_a      [N_DUT];
  logic        mosi_a      [N_DUT];
  logic [31:0] tx_data_a   [N_DUT];
  logic        tx_load_a   [N_DUT];
  logic        rx_ack_a    [N_DUT];
  logic        clr_flags_a [N_DUT];

  wire         miso_a      [N_DUT];
  wire         tx_ready_a  [N_DUT];
  wire  [31:0] rx_data_a   [N_DUT];
  wire         rx_valid_a  [N_DUT];
  wire         overrun_a   [N_DUT];
  wire         underrun_a  [N_DUT];
  wire         busy_a      [N_DUT];

  // Instance configuration: 0..3 = modes 0..3, 4 = mode 0 LSB-first,
  // 5 = mode 0 with 16-bit words.
  function automatic bit cpol_of(input int d);  return (d == 2) || (d == 3); endfunction
  function automatic bit cpha_of(input int d);  return (d == 1) || (d == 3); endfunction
  function automatic bit msb_of(input int d);   return d != 4;               endfunction
  function automatic int width_of(input int d); return (d == 5) ? 16 : 8;    endfunction

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    localparam int W  = (g == 5) ? 16 : 8;
    localparam bit CP = (g == 2) || (g == 3);
    localparam bit CH = (g == 1) || (g == 3);
    localparam bit MF = (g != 4);
    wire [W-1:0] rxd;

    spi_slave_sync #(
      .DATA_W(W), .CPOL(CP), .CPHA(CH), .MSB_FIRST(MF), .SYNC_STG(2)
    ) dut (
      .sys_clk   (clk),
      .rst       (rst),
      .ss        (ss_a[g]),
      .sclk      (sclk_a[g]),
      .mosi      (mosi_a[g]),
      .miso      (miso_a[g]),
      .tx_data   (tx_data_a[g][W-1:0]),
      .tx_load   (tx_load_a[g]),
      .tx_ready  (tx_ready_a[g]),
      .rx_data   (rxd),
      .rx_valid  (rx_valid_a[g]),
      .rx_ack    (rx_ack_a[g]),
      .clr_flags (clr_flags_a[g]),
      .overrun   (overrun_a[g]),
      .underrun  (underrun_a[g]),
      .busy      (busy_a[g])
    );

    assign rx_data_a[g] = 32'(rxd);
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n cycles, landing 1 time unit after the rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Order in which a word appears on the wire, packed first-bit-highest.
  function automatic logic [31:0] to_wire(input int d, input logic [31:0] word);
    logic [31:0] r;
    int w;
    w = width_of(d);
    r = '0;
    for (int i = 0; i < w; i++)
      r[i] = msb_of(d) ? word[i] : word[w-1-i];
    return r;
  endfunction

  task automatic pulse_load(input int d, input logic [31:0] val);
    tx_data_a[d] = val;
    tx_load_a[d] = 1'b1;
    tick(1);
    tx_load_a[d] = 1'b0;
    tick(1);
  endtask

  task automatic pulse_ack(input int d);
    rx_ack_a[d] = 1'b1;
    tick(1);
    rx_ack_a[d] = 1'b0;
    tick(1);
  endtask

  task automatic pulse_clr(input int d);
    clr_flags_a[d] = 1'b1;
    tick(1);
    clr_flags_a[d] = 1'b0;
    tick(1);
  endtask

  // SPI master: shifts nbits of mosi_wire (highest bit first) and returns
  // what it sampled on miso in the same packing.
  task automatic spi_xfer(input int d, input int nbits, input logic [31:0] mosi_wire,
                          output logic [31:0] miso_wire, input bit keep_ss);
    logic idle;
    idle      = cpol_of(d);
    miso_wire = '0;
    ss_a[d]   = 1'b1;
    tick(HALF);
    for (int i = nbits - 1; i >= 0; i--) begin
      if (!cpha_of(d)) begin
        mosi_a[d]    = mosi_wire[i];
        tick(HALF);
        sclk_a[d]    = ~idle;
        miso_wire[i] = miso_a[d];
        tick(HALF);
        sclk_a[d]    = idle;
      end else begin
        sclk_a[d]    = ~idle;
        mosi_a[d]    = mosi_wire[i];
        tick(HALF);
        sclk_a[d]    = idle;
        miso_wire[i] = miso_a[d];
        tick(HALF);
      end
    end
    tick(HALF);
    if (!keep_ss) begin
      ss_a[d]   = 1'b0;
      mosi_a[d] = 1'b0;
      tick(HALF);
    end
  endtask

  task automatic wait_valid(input int d);
    for (int i = 0; i < 50 && !rx_valid_a[d]; i++) tick(1);
  endtask

  // One full-word frame: optional TX load, scoreboard push, transfer, then
  // pop/compare, acknowledge and flag clear.
  task automatic exchange(input int d, input string tag, input bit do_load,
                          input logic [31:0] tx, input logic [31:0] rx_word);
    logic [31:0] got;
    if (do_load) pulse_load(d, tx);
    exp_q.push_back(rx_word);
    exp_q.push_back(to_wire(d, tx));
    spi_xfer(d, width_of(d), to_wire(d, rx_word), got, 1'b0);
    wait_valid(d);
    check({tag, "_rx_valid"}, 32'(rx_valid_a[d]), 32'd1);
    check({tag, "_rx_data"},  rx_data_a[d], exp_q.pop_front());
    check({tag, "_miso"},     got,          exp_q.pop_front());
    check({tag, "_busy"},     32'(busy_a[d]), 32'd0);
    pulse_ack(d);
    check({tag, "_acked"},    32'(rx_valid_a[d]), 32'd0);
    pulse_clr(d);
  endtask

  function automatic logic [31:0] status(input int d);
    return 32'({miso_a[d], rx_valid_a[d], tx_ready_a[d],
                overrun_a[d], underrun_a[d], busy_a[d]});
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] got;

    rst = 1'b1;
    for (int d = 0; d < N_DUT; d++) begin
      ss_a[d] = 1'b0; sclk_a[d] = cpol_of(d); mosi_a[d] = 1'b0;
      tx_data_a[d] = '0; tx_load_a[d] = 1'b0; rx_ack_a[d] = 1'b0; clr_flags_a[d] = 1'b0;
    end
    tick(4);
    rst = 1'b0;
    tick(2);

    // Reset state: {miso,rx_valid,tx_ready,overrun,underrun,busy}
    check("reset_status",  status(0),    32'b001000);
    check("reset_rx_data", rx_data_a[0], 32'h0);

    // Mode 0 basic exchange.
    pulse_load(0, 32'hA5);
    check("load_not_ready", 32'(tx_ready_a[0]), 32'd0);
    exchange(0, "mode0", 1'b0, 32'hA5, 32'h3C);
    check("mode0_ready_after", 32'(tx_ready_a[0]), 32'd1);

    // Modes 1, 2, 3.
    for (int d = 1; d <= 3; d++) exchange(d, $sformatf("mode%0d", d), 1'b1, 32'hA5, 32'h3C);

    // LSB-first: wire order reversed relative to the word.
    exchange(4, "lsb", 1'b1, 32'hC1, 32'h2D);
    check("lsb_wire_order", to_wire(4, 32'hC1), 32'h83);

    // Two words in one frame, no ack: second word overruns; second TX word
    // finds the holding register empty.
    pulse_load(0, 32'h5A);
    exp_q.push_back(32'h11);
    exp_q.push_back(32'h5A00);
    spi_xfer(0, 16, 32'h1122, got, 1'b0);
    check("two_rx_data",  rx_data_a[0], exp_q.pop_front());
    check("two_miso",     got,          exp_q.pop_front());
    check("two_overrun",  32'(overrun_a[0]),  32'd1);
    check("two_underrun", 32'(underrun_a[0]), 32'd1);
    check("two_rx_valid", 32'(rx_valid_a[0]), 32'd1);
    pulse_clr(0);
    check("clr_overrun",  32'(overrun_a[0]),  32'd0);
    check("clr_underrun", 32'(underrun_a[0]), 32'd0);
    pulse_ack(0);

    // No load before the frame: zeros on miso and underrun.
    exp_q.push_back(32'h77);
    exp_q.push_back(32'h00);
    spi_xfer(0, 8, 32'h77, got, 1'b0);
    check("under_rx_data",  rx_data_a[0], exp_q.pop_front());
    check("under_miso",     got,          exp_q.pop_front());
    check("under_underrun", 32'(underrun_a[0]), 32'd1);
    pulse_ack(0);
    pulse_clr(0);

    // Load while full is ignored; the first word stays in the holding reg.
    pulse_load(0, 32'h99);
    pulse_load(0, 32'h42);
    check("full_not_ready", 32'(tx_ready_a[0]), 32'd0);
    exchange(0, "hold_kept", 1'b0, 32'h99, 32'h96);

    // Select drops after 5 bits: partial word discarded.
    pulse_load(0, 32'h0F);
    spi_xfer(0, 5, 32'h1B, got, 1'b0);
    tick(4);
    check("partial_rx_valid", 32'(rx_valid_a[0]), 32'd0);
    check("partial_busy",     32'(busy_a[0]),     32'd0);
    check("partial_miso",     32'(miso_a[0]),     32'd0);
    exchange(0, "after_partial", 1'b1, 32'hF0, 32'h81);

    // Reset mid-word on the 16-bit instance.
    pulse_load(5, 32'h1234);
    spi_xfer(5, 6, 32'h2A, got, 1'b1);
    check("mid_busy", 32'(busy_a[5]), 32'd1);
    rst = 1'b1;
    tick(1);
    check("rst_mid_status",  status(5),    32'b001000);
    check("rst_mid_rx_data", rx_data_a[5], 32'h0);
    ss_a[5]   = 1'b0;
    mosi_a[5] = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(4);
    exchange(5, "w16", 1'b1, 32'hCAFE, 32'hBEEF);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
